// File: rtl/divider_16by8_pkg.sv
// Shared constants and FSM encoding
// for the 16-by-8 restoring divider.
package divider_16by8_pkg;

  localparam int WN = 8;
  localparam int N_ITER = WN;
  localparam int CNT_W = $clog2(N_ITER);

  localparam logic [WN-1:0] OVF_RES = 8'hFF;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_CHECK  = 2'd1,
    S_ITER   = 2'd2,
    S_FINISH = 2'd3
  } state_t;

endpackage

// File: rtl/divider_16by8_if.sv
// Request/result bundle between a
// requester and the divider.
interface divider_16by8_if #(
  parameter int WN = 8
);

  logic            start;
  logic [2*WN-1:0] dividend;
  logic [WN-1:0]   divisor;
  logic [WN-1:0]   quotient;
  logic [WN-1:0]   remainder;
  logic            BUSY;
  logic            DONE;
  logic            OVF;

  modport master (
    output start,
    output dividend,
    output divisor,
    input  quotient,
    input  remainder,
    input  BUSY,
    input  DONE,
    input  OVF
  );

  modport slave (
    input  start,
    input  dividend,
    input  divisor,
    output quotient,
    output remainder,
    output BUSY,
    output DONE,
    output OVF
  );

endinterface

// File: rtl/divider_16by8_fd.sv
// Divider datapath: operand, partial
// remainder and quotient registers.
module divider_16by8_fd
  import divider_16by8_pkg::*;
#(
  parameter int WN = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic            step,
  input  logic            ovf_set,
  input  logic            res_load,
  input  logic [2*WN-1:0] dividend,
  input  logic [WN-1:0]   divisor,
  output logic            ovf_cond,
  output logic [WN-1:0]   quotient,
  output logic [WN-1:0]   remainder
);

  // prem_q starts as the dividend high
  // half; lq_q starts as the low half
  // and fills with quotient bits as the
  // dividend bits shift out of its MSB.
  logic [WN:0]   prem_q;
  logic [WN-1:0] lq_q;
  logic [WN-1:0] dvs_q;
  logic [WN-1:0] q_res;
  logic [WN-1:0] r_res;

  logic [WN:0]   shifted;
  logic [WN:0]   diff;
  logic          ge;
  logic [WN:0]   p_nxt;
  logic [WN-1:0] lq_nxt;

  assign shifted = {prem_q[WN-1:0], lq_q[WN-1]};
  assign diff    = shifted - {1'b0, dvs_q};
  assign ge      = shifted >= {1'b0, dvs_q};
  assign p_nxt   = ge ? diff : shifted;
  assign lq_nxt  = {lq_q[WN-2:0], ge};

  // Quotient would not fit in WN bits.
  assign ovf_cond = (dvs_q == '0) ||
                    (prem_q >= {1'b0, dvs_q});

  assign quotient  = q_res;
  assign remainder = r_res;

  // Working registers and held results;
  // results change only when a final
  // value is ready.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prem_q <= '0;
      lq_q   <= '0;
      dvs_q  <= '0;
      q_res  <= '0;
      r_res  <= '0;
    end else begin
      if (load) begin
        prem_q <= {1'b0, dividend[2*WN-1:WN]};
        lq_q   <= dividend[WN-1:0];
        dvs_q  <= divisor;
      end else if (step) begin
        prem_q <= p_nxt;
        lq_q   <= lq_nxt;
      end
      if (ovf_set) begin
        q_res <= OVF_RES;
        r_res <= OVF_RES;
      end else if (res_load) begin
        q_res <= lq_nxt;
        r_res <= p_nxt[WN-1:0];
      end
    end
  end

endmodule

// File: rtl/divider_16by8.sv
// 16-by-8 unsigned restoring divider:
// control FSM, step counter, flags.
module divider_16by8
  import divider_16by8_pkg::*;
#(
  parameter int WN = 8
) (
  input  logic           CLK,
  input  logic           RESET,
  divider_16by8_if.slave bus
);

  state_t state_q;
  state_t state_d;

  logic [CNT_W-1:0] cnt_q;
  logic             last;
  logic             load;
  logic             step;
  logic             ovf_set;
  logic             res_load;
  logic             ovf_cond;
  logic             busy;
  logic             done;
  logic             ovf_q;

  assign last = cnt_q == CNT_W'(N_ITER - 1);

  // State register.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (bus.start) state_d = S_CHECK;
      S_CHECK:  state_d = ovf_cond ? S_FINISH : S_ITER;
      S_ITER:   if (last) state_d = S_FINISH;
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Control strobes and status outputs.
  always_comb begin
    busy     = 1'b1;
    done     = 1'b0;
    load     = 1'b0;
    step     = 1'b0;
    ovf_set  = 1'b0;
    res_load = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        busy = 1'b0;
        load = bus.start;
      end
      S_CHECK:  ovf_set = ovf_cond;
      S_ITER: begin
        step     = 1'b1;
        res_load = last;
      end
      S_FINISH: done = 1'b1;
      default:  busy = 1'b0;
    endcase
  end

  // Iteration counter, cleared on accept.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= '0;
    end else if (step) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // Overflow flag, updated with results.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      ovf_q <= 1'b0;
    end else if (ovf_set) begin
      ovf_q <= 1'b1;
    end else if (res_load) begin
      ovf_q <= 1'b0;
    end
  end

  divider_16by8_fd #(
    .WN(WN)
  ) u_fd (
    .clk      (CLK),
    .rst      (RESET),
    .load     (load),
    .step     (step),
    .ovf_set  (ovf_set),
    .res_load (res_load),
    .dividend (bus.dividend),
    .divisor  (bus.divisor),
    .ovf_cond (ovf_cond),
    .quotient (bus.quotient),
    .remainder(bus.remainder)
  );

  assign bus.BUSY = busy;
  assign bus.DONE = done;
  assign bus.OVF  = ovf_q;

endmodule
